ofm_writeback: RTL and testbench
================================

Name: ofm_writeback

Overview:
- Return path of the conv sub-top: takes one OFM vector (16 lanes x 8 bit) from the PE cluster per output pixel.
- Packs each vector into 32-bit words and writes them sequentially into the OFM BRAM, starting at a programmed base address.
- Runs a start/done job for a programmed pixel count.
- Uses a valid/ready handshake on the PE side and a write/ready handshake on the memory side.

Parameters:
- NUM_PE, 16, number of OFM lanes (8 bit each) per vector.
- DATA_W, 32, BRAM write data width; WORDS = NUM_PE*8/DATA_W = 4.
- ADDR_W, 20, BRAM word-address width.
- CNT_W, 16, pixel counter width.

Ports:
- clk  in  1  clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle job start; honoured only in IDLE.
- base_addr  in  ADDR_W  first BRAM word address; latched on start.
- num_pixels  in  CNT_W  number of OFM vectors in the job; latched on start.
- ofm_valid  in  1  OFM vector available.
- ofm_ready  out  1  block can accept a vector.
- ofm_data  in  NUM_PE*8  lane k occupies bits [8k+7:8k].
- mem_we  out  1  BRAM write request.
- mem_addr  out  ADDR_W  BRAM write address.
- mem_wdata  out  DATA_W  BRAM write data.
- mem_ready  in  1  BRAM accepts the write this cycle.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle job-complete pulse.
- pixel_cnt  out  CNT_W  vectors fully written in the current job.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - ofm_ready, mem_we, busy and done go to 0.
  - mem_addr, mem_wdata, pixel_cnt, the capture buffer and word_idx go to 0.
- IDLE:
  - ofm_ready=0.
  - start with num_pixels==0: done=1 on the next cycle; stay in IDLE.
  - start with num_pixels!=0: latch base_addr into an address register and num_pixels into a limit register, clear pixel_cnt, go to ACCEPT.
- ACCEPT:
  - ofm_ready=1.
  - On ofm_valid&&ofm_ready: capture ofm_data into the buffer, set word_idx=0, go to WRITE.
- WRITE:
  - ofm_ready=0, mem_we=1, mem_addr=address register, mem_wdata=buffer[word_idx*DATA_W +: DATA_W].
  - Word 0 holds lanes 3..0, with lane 0 in bits [7:0].
  - On mem_ready: increment the address and word_idx.
  - On the last word (word_idx==WORDS-1) with mem_ready: pixel_cnt+1. If the new count equals the limit, go to DONE; otherwise go to ACCEPT.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in the same cycle done is high.
- Timing:
  - First mem_we is asserted in the cycle after the ofm handshake.
  - With mem_ready held at 1, throughput is one vector per WORDS+1 cycles.
- Backpressure: while mem_we=1 and mem_ready=0, mem_addr and mem_wdata hold stable. No word is skipped or duplicated.
- mem_wdata=0 whenever mem_we=0.
- ofm_valid while ofm_ready=0 is ignored; the upstream holds its data.
- The address wraps modulo 2^ADDR_W; no error is flagged.
- start outside IDLE is ignored; the latched parameters do not change.
- Reset asserted mid-job aborts the job. No done pulse is produced; partial BRAM writes are left in place.

Test Plan:
- Reset: hold reset=0 with random inputs -> all outputs 0; after release, state is IDLE, ofm_ready=0 and busy=0.
- Single pixel: base_addr=0x00010, num_pixels=1, ofm_data lanes = 0x00..0x0F, mem_ready=1.
  - Required: four consecutive writes — addr 0x10 data 0x03020100, addr 0x11 data 0x07060504, addr 0x12 data 0x0B0A0908, addr 0x13 data 0x0F0E0D0C.
  - Then one done pulse, pixel_cnt=1, busy drops.
- Backpressure on 3 pixels: mem_ready=0 for 3 cycles while word 2 of pixel 1 is presented -> mem_addr and mem_wdata held.
  - Exactly 12 writes at base..base+11 with correct data; done once.
- Zero length: start with num_pixels=0 -> done=1 one cycle later, mem_we never asserted, ofm_ready stays 0.
- Wrap: base_addr=0xFFFFE, num_pixels=1 -> write addresses 0xFFFFE, 0xFFFFF, 0x00000, 0x00001.
- Abort/restart:
  - Assert reset during word 1 of pixel 0 -> outputs clear immediately.
  - Then start with base 0x100 and num_pixels=2 -> 8 clean writes at 0x100..0x107, done once.
  - A second start pulse sent mid-job is ignored.

Source files
------------

// File: rtl/ofm_writeback.sv
// OFM return path: captures one NUM_PE-lane vector per pixel and streams it
// as WORDS consecutive BRAM writes starting at a programmed base address.
module ofm_writeback #(
  parameter int NUM_PE = 16,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 20,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      num_pixels,
  input  logic                  ofm_valid,
  output logic                  ofm_ready,
  input  logic [NUM_PE*8-1:0]   ofm_data,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic                  mem_ready,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_W-1:0]      pixel_cnt
);

  localparam int WORDS = NUM_PE * 8 / DATA_W;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCEPT = 2'd1;
  localparam logic [1:0] S_WRITE  = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]            state;
  logic [ADDR_W-1:0]     addr;
  logic [CNT_W-1:0]      limit;
  logic [NUM_PE*8-1:0]   buffer;
  logic [IDX_W-1:0]      word_idx;
  logic                  zero_done;
  logic [DATA_W-1:0]     words [WORDS];
  logic                  last_word;
  logic [CNT_W-1:0]      cnt_next;

  always_comb begin
    for (int w = 0; w < WORDS; w++) begin
      words[w] = buffer[w*DATA_W +: DATA_W];
    end
  end

  assign last_word = (word_idx == IDX_W'(WORDS - 1));
  assign cnt_next  = pixel_cnt + 1'b1;

  assign ofm_ready = (state == S_ACCEPT);
  assign mem_we    = (state == S_WRITE);
  assign mem_addr  = addr;
  assign mem_wdata = (state == S_WRITE) ? words[word_idx] : '0;
  // busy deliberately drops in the done cycle so the two never overlap
  assign busy      = (state == S_ACCEPT) || (state == S_WRITE);
  assign done      = (state == S_DONE) || zero_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      addr      <= '0;
      limit     <= '0;
      buffer    <= '0;
      word_idx  <= '0;
      pixel_cnt <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (num_pixels == '0) begin
              zero_done <= 1'b1;
            end else begin
              addr      <= base_addr;
              limit     <= num_pixels;
              pixel_cnt <= '0;
              state     <= S_ACCEPT;
            end
          end
        end
        S_ACCEPT: begin
          if (ofm_valid) begin
            buffer   <= ofm_data;
            word_idx <= '0;
            state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          // address and word index only move on an accepted write
          if (mem_ready) begin
            addr     <= addr + 1'b1;
            word_idx <= word_idx + 1'b1;
            if (last_word) begin
              pixel_cnt <= cnt_next;
              state     <= (cnt_next == limit) ? S_DONE : S_ACCEPT;
            end
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ofm_writeback.sv
// Directed bench for ofm_writeback: BRAM writes are checked against a
// scoreboard filled when each OFM vector is offered.
module tb_ofm_writeback;
  localparam int NUM_PE = 16;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 20;
  localparam int CNT_W  = 16;

  logic                clk;
  logic                reset;
  logic                start;
  logic [ADDR_W-1:0]   base_addr;
  logic [CNT_W-1:0]    num_pixels;
  logic                ofm_valid;
  logic                ofm_ready;
  logic [NUM_PE*8-1:0] ofm_data;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_ready;
  logic                busy;
  logic                done;
  logic [CNT_W-1:0]    pixel_cnt;

  ofm_writeback #(
    .NUM_PE(NUM_PE), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
    .num_pixels(num_pixels), .ofm_valid(ofm_valid), .ofm_ready(ofm_ready),
    .ofm_data(ofm_data), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .busy(busy), .done(done),
    .pixel_cnt(pixel_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  int done_seen = 0;

  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W-1:0] exp_data_q [$];
  logic [ADDR_W-1:0] next_addr;

  logic              hold_pending = 1'b0;
  logic [ADDR_W-1:0] prev_addr;
  logic [DATA_W-1:0] prev_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: write ordering, backpressure stability, idle data, done pulses.
  always @(negedge clk) begin
    logic [ADDR_W-1:0] ea;
    logic [DATA_W-1:0] ed;
    if (!mem_we) check("wdata_idle_zero", 64'(mem_wdata), 64'd0);
    if (hold_pending) begin
      check("hold_we", 64'(mem_we), 64'd1);
      check("hold_addr", 64'(mem_addr), 64'(prev_addr));
      check("hold_data", 64'(mem_wdata), 64'(prev_data));
    end
    if (mem_we && mem_ready) begin
      check("write_expected", 64'(exp_addr_q.size() > 0), 64'd1);
      if (exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        ed = exp_data_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(ea));
        check("wr_data", 64'(mem_wdata), 64'(ed));
      end
    end
    hold_pending = mem_we && !mem_ready && reset;
    prev_addr    = mem_addr;
    prev_data    = mem_wdata;
    if (done) done_seen++;
  end

  task automatic push_words(input logic [NUM_PE*8-1:0] v, input int nwords);
    logic [DATA_W-1:0] wd;
    for (int w = 0; w < nwords; w++) begin
      for (int b = 0; b < 4; b++) wd[b*8 +: 8] = v[(4*w + b)*8 +: 8];
      exp_addr_q.push_back(next_addr);
      exp_data_q.push_back(wd);
      next_addr = next_addr + 1'b1;
    end
  endtask

  // Offers one vector and returns one cycle after the handshake edge.
  task automatic send_pixel(input logic [NUM_PE*8-1:0] v, input int nwords);
    bit ok;
    ok = 1'b0;
    push_words(v, nwords);
    ofm_valid = 1'b1;
    ofm_data  = v;
    for (int i = 0; i < 100; i++) begin
      if (ofm_ready) begin
        tick();
        ok = 1'b1;
        break;
      end
      tick();
    end
    ofm_valid = 1'b0;
    if (!ok) check("ofm_handshake", 64'(ofm_ready), 64'd1);
  endtask

  task automatic start_job(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n);
    next_addr  = b;
    base_addr  = b;
    num_pixels = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic wait_done(input int n_exp);
    for (int i = 0; i < 200; i++) begin
      if (done) break;
      tick();
    end
    check("done_pulse", 64'(done), 64'd1);
    check("busy_at_done", 64'(busy), 64'd0);
    check("pixel_cnt_final", 64'(pixel_cnt), 64'(n_exp));
    tick();
    check("done_single", 64'(done), 64'd0);
  endtask

  function automatic logic [NUM_PE*8-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    logic [NUM_PE*8-1:0] v0, v1, v2;

    // Reset with random inputs: every output must read zero.
    reset = 1'b0;
    next_addr = '0;
    for (int i = 0; i < 4; i++) begin
      start      = 1'($urandom);
      base_addr  = ADDR_W'($urandom);
      num_pixels = CNT_W'($urandom);
      ofm_valid  = 1'($urandom);
      ofm_data   = rand_vec();
      mem_ready  = 1'($urandom);
      tick();
      check("reset_outputs", 64'({ofm_ready, mem_we, busy, done, mem_addr, mem_wdata}), 64'd0);
      check("reset_pixel_cnt", 64'(pixel_cnt), 64'd0);
    end
    start = 1'b0; ofm_valid = 1'b0; ofm_data = '0; mem_ready = 1'b1;
    base_addr = '0; num_pixels = '0;
    tick();
    reset = 1'b1;
    tick();
    check("idle_ofm_ready", 64'(ofm_ready), 64'd0);
    check("idle_busy", 64'(busy), 64'd0);

    // Single pixel, lanes 0x00..0x0F at base 0x10.
    d0 = done_seen;
    start_job(20'h00010, 16'd1);
    check("accept_busy", 64'(busy), 64'd1);
    exp_addr_q.push_back(20'h00010); exp_data_q.push_back(32'h03020100);
    exp_addr_q.push_back(20'h00011); exp_data_q.push_back(32'h07060504);
    exp_addr_q.push_back(20'h00012); exp_data_q.push_back(32'h0B0A0908);
    exp_addr_q.push_back(20'h00013); exp_data_q.push_back(32'h0F0E0D0C);
    send_pixel(128'h0F0E0D0C0B0A09080706050403020100, 0);
    for (int w = 0; w < 4; w++) begin
      check("single_we", 64'(mem_we), 64'd1);
      check("single_addr", 64'(mem_addr), 64'(20'h00010 + w));
      check("single_ofm_ready", 64'(ofm_ready), 64'd0);
      tick();
    end
    check("single_done", 64'(done), 64'd1);
    check("single_busy", 64'(busy), 64'd0);
    check("single_cnt", 64'(pixel_cnt), 64'd1);
    tick();
    check("single_done_drop", 64'(done), 64'd0);
    check("single_done_count", 64'(done_seen - d0), 64'd1);

    // Three pixels with a 3-cycle stall on word 2 of pixel 1.
    d0 = done_seen;
    v0 = rand_vec(); v1 = rand_vec(); v2 = rand_vec();
    start_job(20'h00400, 16'd3);
    send_pixel(v0, 4);
    send_pixel(v1, 4);
    tick();
    tick();
    mem_ready = 1'b0;
    check("bp_addr", 64'(mem_addr), 64'h406);
    check("bp_data", 64'(mem_wdata), 64'(v1[95:64]));
    repeat (3) tick();
    mem_ready = 1'b1;
    send_pixel(v2, 4);
    wait_done(3);
    check("bp_done_count", 64'(done_seen - d0), 64'd1);
    check("bp_drained", 64'(exp_addr_q.size()), 64'd0);

    // Zero-length job.
    d0 = done_seen;
    base_addr = 20'h00555; num_pixels = 16'd0; start = 1'b1;
    tick();
    start = 1'b0;
    check("zero_done", 64'(done), 64'd1);
    check("zero_ofm_ready", 64'(ofm_ready), 64'd0);
    check("zero_busy", 64'(busy), 64'd0);
    tick();
    check("zero_done_drop", 64'(done), 64'd0);
    check("zero_ofm_ready2", 64'(ofm_ready), 64'd0);
    repeat (3) tick();
    check("zero_done_count", 64'(done_seen - d0), 64'd1);

    // Address wrap at the top of the BRAM.
    start_job(20'hFFFFE, 16'd1);
    send_pixel(rand_vec(), 4);
    wait_done(1);
    check("wrap_drained", 64'(exp_addr_q.size()), 64'd0);

    // Abort during word 1 of pixel 0.
    d0 = done_seen;
    start_job(20'h00200, 16'd1);
    send_pixel(rand_vec(), 1);
    tick();
    check("abort_pre_we", 64'(mem_we), 64'd1);
    check("abort_pre_addr", 64'(mem_addr), 64'h201);
    reset = 1'b0;
    #1;
    check("abort_outputs", 64'({ofm_ready, mem_we, busy, done, mem_addr, mem_wdata}), 64'd0);
    check("abort_pixel_cnt", 64'(pixel_cnt), 64'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();
    check("abort_no_done", 64'(done_seen - d0), 64'd0);
    check("abort_idle", 64'(busy), 64'd0);

    // Restart; a second start mid-job must be ignored.
    d0 = done_seen;
    start_job(20'h00100, 16'd2);
    send_pixel(rand_vec(), 4);
    base_addr = 20'h00300; num_pixels = 16'd7; start = 1'b1;
    tick();
    start = 1'b0;
    send_pixel(rand_vec(), 4);
    wait_done(2);
    check("restart_done_count", 64'(done_seen - d0), 64'd1);
    repeat (3) tick();
    check("restart_stays_idle", 64'(busy), 64'd0);
    check("sb_drained", 64'(exp_addr_q.size()), 64'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
